// File: rtl/ra_link_stack_pkg.sv
// Shared constants and types for the return-address link stack.
package ra_link_stack_pkg;

  localparam logic [4:0] REG_RA      = 5'd31;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;
  localparam int         LINK_OFFSET = 4;
  localparam int         RAS_DEPTH   = 8;

  // Stack operation chosen for the current cycle (before flush override).
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } stack_op_e;

  // Decode helper for the R-type funct field of a JR.
  function automatic logic is_jr_funct(input logic [5:0] funct);
    return funct == FUNCT_JR;
  endfunction

endpackage

// File: rtl/ra_link_stack_if.sv
// Bus between decode/control and the return-address link stack.
// Handshake: there is no backpressure. call_en, ret_en and flush are
// single-cycle strobes that the stack always accepts on the rising edge they
// are sampled; link_we, pred_valid and mispredict are single-cycle result
// strobes one cycle later, and link_data/pred_addr hold between strobes.
interface ra_link_stack_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          call_en;
  logic [AW-1:0] call_pc;
  logic          ret_en;
  logic [AW-1:0] ret_target;
  logic          link_we;
  logic [4:0]    link_addr;
  logic [AW-1:0] link_data;
  logic          pred_valid;
  logic [AW-1:0] pred_addr;
  logic          mispredict;
  logic [DW-1:0] depth;
  logic          overflow;

  modport master (
    output flush, call_en, call_pc, ret_en, ret_target,
    input  link_we, link_addr, link_data, pred_valid, pred_addr,
           mispredict, depth, overflow
  );

  modport slave (
    input  flush, call_en, call_pc, ret_en, ret_target,
    output link_we, link_addr, link_data, pred_valid, pred_addr,
           mispredict, depth, overflow
  );

endinterface

// File: rtl/ra_link_stack_mem.sv
// DEPTH x AW register array: one synchronous write port, one async read port.
module ra_link_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  // Entry write; contents are not reset, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ra_link_stack.sv
// Return-address link stack: $ra link write generation, circular RAS push/pop,
// and registered JR target prediction with mispredict detection.
module ra_link_stack
  import ra_link_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = 32
) (
  input logic           clk,
  input logic           reset,
  ra_link_stack_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] tos;
  logic [CW-1:0] count;
  logic [AW-1:0] link;
  logic [AW-1:0] top_val;
  logic          full;
  logic          pop_ok;
  stack_op_e     op;
  logic          mem_we;
  logic [PW-1:0] waddr;

  logic          link_we_q;
  logic [AW-1:0] link_data_q;
  logic          pred_valid_q;
  logic [AW-1:0] pred_addr_q;
  logic          mispredict_q;
  logic          overflow_q;

  assign link   = bus.call_pc + AW'(LINK_OFFSET);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = bus.ret_en && (count != '0);

  // Classify the cycle; a return on an empty stack is ignored.
  always_comb begin
    op = OP_NONE;
    if (bus.call_en && pop_ok) op = OP_SWAP;
    else if (bus.call_en)      op = OP_PUSH;
    else if (pop_ok)           op = OP_POP;
  end

  // Memory write: a push lands above the top, a swap replaces the top.
  always_comb begin
    mem_we = 1'b0;
    waddr  = tos;
    if (!reset && !bus.flush) begin
      case (op)
        OP_PUSH: begin
          mem_we = 1'b1;
          waddr  = tos + PW'(1);
        end
        OP_SWAP: begin
          mem_we = 1'b1;
          waddr  = tos;
        end
        default: ;
      endcase
    end
  end

  ra_link_stack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (link),
    .raddr (tos),
    .rdata (top_val)
  );

  // Top pointer and live count; a push on a full stack wraps over the oldest.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      tos   <= '0;
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          tos <= tos + PW'(1);
          if (!full) count <= count + CW'(1);
        end
        OP_POP: begin
          tos   <= tos - PW'(1);
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else if (!bus.flush && op == OP_PUSH && full) overflow_q <= 1'b1;
  end

  // Registered link write and prediction outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_we_q    <= 1'b0;
      link_data_q  <= '0;
      pred_valid_q <= 1'b0;
      pred_addr_q  <= '0;
      mispredict_q <= 1'b0;
    end else begin
      link_we_q    <= bus.call_en;
      if (bus.call_en) link_data_q <= link;
      pred_valid_q <= pop_ok;
      mispredict_q <= pop_ok && (top_val != bus.ret_target);
      if (pop_ok) pred_addr_q <= top_val;
    end
  end

  assign bus.link_we    = link_we_q;
  assign bus.link_addr  = REG_RA;
  assign bus.link_data  = link_data_q;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_addr  = pred_addr_q;
  assign bus.mispredict = mispredict_q;
  assign bus.depth      = count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ra_link_stack.sv
// Bench for ra_link_stack: queue-based reference model, per-cycle compare,
// and directed scenarios with literal expectations.
module tb_ra_link_stack;

  localparam int AW    = 32;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;

  ra_link_stack_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  ra_link_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stack as a bounded queue: back is the top, front is the oldest entry.
  logic [AW-1:0] st[$];
  logic          e_link_we, e_pred_valid, e_mis, e_ovf;
  logic [AW-1:0] e_link_data, e_pred_addr;
  logic          model_live = 1'b0;

  always @(posedge clk) begin
    logic          pop_ok;
    logic [AW-1:0] top;
    model_live = 1'b1;
    if (reset) begin
      st.delete();
      e_link_we = 0; e_pred_valid = 0; e_mis = 0; e_ovf = 0;
      e_link_data = '0; e_pred_addr = '0;
    end else begin
      e_link_we = bus.call_en;
      if (bus.call_en) e_link_data = bus.call_pc + 32'd4;
      pop_ok = bus.ret_en && (st.size() > 0);
      e_pred_valid = pop_ok;
      e_mis = 1'b0;
      if (pop_ok) begin
        top = st[st.size()-1];
        e_pred_addr = top;
        e_mis = (top != bus.ret_target);
      end
      if (bus.flush) st.delete();
      else begin
        if (pop_ok) void'(st.pop_back());
        if (bus.call_en) begin
          st.push_back(bus.call_pc + 32'd4);
          if (st.size() > DEPTH) begin
            void'(st.pop_front());
            e_ovf = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("m_link_we",    AW'(bus.link_we),    AW'(e_link_we));
      check("m_link_addr",  AW'(bus.link_addr),  32'd31);
      check("m_link_data",  bus.link_data,       e_link_data);
      check("m_pred_valid", AW'(bus.pred_valid), AW'(e_pred_valid));
      check("m_pred_addr",  bus.pred_addr,       e_pred_addr);
      check("m_mispredict", AW'(bus.mispredict), AW'(e_mis));
      check("m_depth",      AW'(bus.depth),      AW'(st.size()));
      check("m_overflow",   AW'(bus.overflow),   AW'(e_ovf));
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic clear_inputs();
    bus.flush = 0; bus.call_en = 0; bus.call_pc = '0;
    bus.ret_en = 0; bus.ret_target = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_call(input logic [AW-1:0] pc);
    bus.call_en = 1; bus.call_pc = pc;
    step();
  endtask

  task automatic do_ret(input logic [AW-1:0] tgt);
    bus.ret_en = 1; bus.ret_target = tgt;
    step();
  endtask

  task automatic do_both(input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    bus.call_en = 1; bus.call_pc = pc;
    bus.ret_en = 1; bus.ret_target = tgt;
    step();
  endtask

  task automatic do_flush();
    bus.flush = 1;
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    clear_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_link_we",    AW'(bus.link_we),    '0);
    check("rst_link_data",  bus.link_data,       '0);
    check("rst_pred_valid", AW'(bus.pred_valid), '0);
    check("rst_pred_addr",  bus.pred_addr,       '0);
    check("rst_mispredict", AW'(bus.mispredict), '0);
    check("rst_depth",      AW'(bus.depth),      '0);
    check("rst_overflow",   AW'(bus.overflow),   '0);
    reset = 0;
    step();

    // Return on an empty stack: no prediction
    do_ret(32'h1234);
    check("empty_pred_valid", AW'(bus.pred_valid), '0);
    check("empty_mispredict", AW'(bus.mispredict), '0);

    // Single call
    do_call(32'h0040_0010);
    check("call_link_we",   AW'(bus.link_we),   32'd1);
    check("call_link_addr", AW'(bus.link_addr), 32'd31);
    check("call_link_data", bus.link_data,      32'h0040_0014);
    check("call_depth",     AW'(bus.depth),     32'd1);
    step();
    check("call_we_pulse",  AW'(bus.link_we),   '0);
    do_ret(32'h0040_0014);
    check("pop1_addr",      bus.pred_addr,      32'h0040_0014);

    // Two pushes, two correct returns
    do_call(32'h100);
    do_call(32'h200);
    do_ret(32'h204);
    check("lifo_addr0", bus.pred_addr,        32'h204);
    check("lifo_mis0",  AW'(bus.mispredict),  '0);
    do_ret(32'h104);
    check("lifo_addr1", bus.pred_addr,        32'h104);
    check("lifo_mis1",  AW'(bus.mispredict),  '0);
    check("lifo_depth", AW'(bus.depth),       '0);

    // Nine calls into eight entries
    for (int i = 1; i <= 9; i++) do_call(32'h1000 + i * 32'h10);
    check("ovf_flag",  AW'(bus.overflow), 32'd1);
    check("ovf_depth", AW'(bus.depth),    32'd8);
    for (int i = 9; i >= 2; i--) begin
      do_ret(32'h1004 + i * 32'h10);
      check("ovf_pred_valid", AW'(bus.pred_valid), 32'd1);
      check("ovf_pred_addr",  bus.pred_addr,        32'h1004 + i * 32'h10);
    end
    do_ret(32'h1014);
    check("ovf_9th_valid", AW'(bus.pred_valid), '0);
    check("ovf_9th_hold",  bus.pred_addr,        32'h1024);

    // Same-cycle call and return replaces the top
    do_call(32'h2FC);
    do_both(32'h500, 32'h300);
    check("swap_addr",  bus.pred_addr,   32'h300);
    check("swap_depth", AW'(bus.depth),  32'd1);
    check("swap_link",  bus.link_data,   32'h504);
    do_ret(32'h504);
    check("swap_next",  bus.pred_addr,   32'h504);

    // Mispredict pulse
    do_call(32'h100);
    do_ret(32'h999);
    check("mis_pulse",  AW'(bus.mispredict), 32'd1);
    check("mis_addr",   bus.pred_addr,       32'h104);
    step();
    check("mis_clear",  AW'(bus.mispredict), '0);
    check("pv_clear",   AW'(bus.pred_valid), '0);

    // Flush keeps overflow
    do_call(32'h10); do_call(32'h20); do_call(32'h30);
    check("pre_flush_depth", AW'(bus.depth), 32'd3);
    do_flush();
    check("flush_depth",    AW'(bus.depth),    '0);
    check("flush_overflow", AW'(bus.overflow), 32'd1);

    // Flush with a call: link still written, stack stays empty
    bus.call_en = 1; bus.call_pc = 32'h40;
    do_flush();
    check("flush_call_we",   AW'(bus.link_we), 32'd1);
    check("flush_call_data", bus.link_data,    32'h44);
    check("flush_call_depth",AW'(bus.depth),   '0);
    do_ret(32'h44);
    check("flush_ret_valid", AW'(bus.pred_valid), '0);

    // Link address wraps modulo 2^AW
    do_call(32'hFFFF_FFFE);
    check("wrap_link", bus.link_data, 32'h0000_0002);
    do_ret(32'h2);
    check("wrap_pred", bus.pred_addr, 32'h0000_0002);

    // Reset during a call drops the link pulse and clears overflow
    do_call(32'h700);
    reset = 1;
    do_call(32'h800);
    check("rst_mid_we",    AW'(bus.link_we),  '0);
    check("rst_mid_depth", AW'(bus.depth),    '0);
    check("rst_mid_ovf",   AW'(bus.overflow), '0);
    reset = 0;
    step();
    do_ret(32'h804);
    check("rst_mid_pop", AW'(bus.pred_valid), '0);

    // Randomised mix checked by the model
    for (int i = 0; i < 150; i++) begin
      bus.call_en    = ($urandom_range(0, 2) == 0);
      bus.call_pc    = {$urandom_range(0, 255), 2'b00};
      bus.ret_en     = ($urandom_range(0, 2) == 0);
      bus.ret_target = ($urandom_range(0, 1) == 0) ? ((st.size() > 0) ? st[st.size()-1] : 32'h0)
                                                   : 32'h0BAD;
      bus.flush      = ($urandom_range(0, 30) == 0);
      step();
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
